// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the instruction-memory bootloader.
//   - loader_state_e : frame-parser state, also exported on the debug port
//   - DEFAULT_*      : default frame constants used as parameter defaults
//   - word_byte_addr : byte address of a word index relative to a base
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_e;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE      = 8'h55;
    localparam logic [31:0] DEFAULT_BASE_ADDR      = 32'h0000_0000;
    localparam int unsigned DEFAULT_MAX_WORDS      = 2**15;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    // Bytes in the little-endian length field that follows the sync byte.
    localparam int unsigned LEN_FIELD_BYTES = 4;

    // Byte address of word 'idx'; the sum wraps modulo 2**32 by design.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// -----------------------------------------------------------------------------
// byte_to_word_packer
//   Assembles four consecutive bytes into a little-endian 32-bit word. The
//   first byte lands in bits 7:0, the fourth in bits 31:24. Used for both the
//   length field and the payload words of a boot frame.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   clear      in   synchronous clear of byte count and assembler
//   in_valid   in   in_byte is valid this cycle
//   in_byte    in   byte to append
//   word       out  assembled word including the current in_byte
//   word_valid out  high in the cycle the fourth byte is presented
//   byte_cnt   out  bytes already held (0..3), for observation
// -----------------------------------------------------------------------------
module byte_to_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [1:0]  byte_cnt
);

    logic [1:0]  cnt_q;
    logic [31:0] shift_q;

    // Shifting right by a byte each time leaves the first byte at the bottom
    // once four bytes have entered. The completed word is exposed
    // combinationally so the consumer can register it on the same edge.
    assign word       = {in_byte, shift_q[31:8]};
    assign word_valid = in_valid && (cnt_q == 2'd3);
    assign byte_cnt   = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else if (clear) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else if (in_valid) begin
            // The 2-bit count wraps to 0 after the fourth byte, ready for the
            // next word without an explicit clear.
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Byte-stream bootloader. Parses frames of the form
//     SYNC, LEN[7:0], LEN[15:8], LEN[23:16], LEN[31:24], LEN*4 payload, CSUM
//   writes each little-endian payload word into instruction memory, and keeps
//   the core in reset until a frame with a matching mod-256 payload checksum
//   has been fully written.
//
// Handshakes: rx_valid is a one-cycle strobe with no back-pressure; every
//   strobe is consumed in the cycle it is seen. we is a one-cycle write
//   strobe with no back-pressure; memory must accept it unconditionally.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   rx_data    in   received byte
//   rx_valid   in   rx_data valid this cycle
//   we         out  instruction-memory write enable, one cycle per word
//   waddr      out  byte write address, 4-aligned
//   wdata      out  write data word
//   core_reset out  holds the CPU in reset while high
//   busy       out  frame in progress
//   done       out  last frame loaded successfully
//   error      out  last frame aborted
//   dbg_state  out  current parser state
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned MAX_WORDS      = DEFAULT_MAX_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          we,
    output logic [31:0]   waddr,
    output logic [31:0]   wdata,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output loader_state_e dbg_state
);

    localparam logic [31:0] MAX_WORDS_W  = 32'(MAX_WORDS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    loader_state_e state_q;
    logic [31:0]   len_q;
    logic [31:0]   word_idx_q;
    logic [7:0]    csum_q;
    logic [31:0]   gap_q;
    // Set while the final payload word is being written; the byte that
    // arrives from then on is the checksum.
    logic          last_q;

    logic          in_frame;
    logic          sync_hit;
    logic          timeout_hit;
    logic          csum_ok;
    logic [7:0]    csum_next;
    logic          pk_clear;
    logic          pk_in_valid;
    logic [31:0]   pk_word;
    logic          pk_word_valid;
    logic [1:0]    pk_byte_cnt;

    assign in_frame    = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign sync_hit    = rx_valid && (rx_data == SYNC_BYTE);
    assign timeout_hit = in_frame && !rx_valid && (gap_q == TIMEOUT_LAST);
    assign csum_ok     = (rx_data == csum_q);
    assign csum_next   = csum_q + rx_data;

    // The packer only sees length and payload bytes; outside a frame it is
    // held clear so every frame starts assembling at byte 0.
    assign pk_clear    = !in_frame;
    assign pk_in_valid = rx_valid && ((state_q == LEN) || ((state_q == DATA) && !last_q));

    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .in_valid   (pk_in_valid),
        .in_byte    (rx_data),
        .word       (pk_word),
        .word_valid (pk_word_valid),
        .byte_cnt   (pk_byte_cnt)
    );

    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            we         <= 1'b0;
            waddr      <= BASE_ADDR;
            wdata      <= 32'd0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_q      <= 32'd0;
            word_idx_q <= 32'd0;
            csum_q     <= 8'd0;
            gap_q      <= 32'd0;
            last_q     <= 1'b0;
        end else begin
            we <= 1'b0;

            // Idle-gap counter: restarts on every byte inside a frame.
            if (in_frame && !rx_valid) begin
                gap_q <= gap_q + 32'd1;
            end else begin
                gap_q <= 32'd0;
            end

            case (state_q)
                IDLE, DONE, ERR: begin
                    if (sync_hit) begin
                        state_q    <= LEN;
                        busy       <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        len_q      <= 32'd0;
                        word_idx_q <= 32'd0;
                        csum_q     <= 8'd0;
                        last_q     <= 1'b0;
                    end
                end

                LEN: begin
                    if (timeout_hit) begin
                        state_q <= ERR;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                    end else if (pk_word_valid) begin
                        len_q <= pk_word;
                        if (pk_word > MAX_WORDS_W) begin
                            state_q <= ERR;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                        end else if (pk_word == 32'd0) begin
                            state_q <= CSUM;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (last_q) begin
                        // The final write is on the bus this cycle; a byte
                        // arriving now is already the checksum.
                        last_q <= 1'b0;
                        if (rx_valid) begin
                            if (csum_ok) begin
                                state_q    <= DONE;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                core_reset <= 1'b0;
                            end else begin
                                state_q <= ERR;
                                error   <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end else if (timeout_hit) begin
                            state_q <= ERR;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= CSUM;
                        end
                    end else if (rx_valid) begin
                        csum_q <= csum_next;
                        if (pk_word_valid) begin
                            we         <= 1'b1;
                            wdata      <= pk_word;
                            waddr      <= word_byte_addr(BASE_ADDR, word_idx_q);
                            word_idx_q <= word_idx_q + 32'd1;
                            if ((word_idx_q + 32'd1) == len_q) begin
                                last_q <= 1'b1;
                            end
                        end
                    end else if (timeout_hit) begin
                        state_q <= ERR;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end

                CSUM: begin
                    if (rx_valid) begin
                        if (csum_ok) begin
                            state_q    <= DONE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            core_reset <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_q <= ERR;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // The packer's byte count is observable on the instance for debug; it is
    // not needed by the parser, which relies on word_valid alone.
    logic unused_ok;
    assign unused_ok = ^pk_byte_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed and randomized frames against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned T    = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 2**15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic rx_valid = 1'b0;

    logic          we;
    logic [31:0]   waddr;
    logic [31:0]   wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;
    loader_state_e dbg_state;

    always #5 clk = ~clk;

    imem_loader #(
        .SYNC_BYTE      (8'h55),
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_a_q[$];
    logic [31:0] got_d[$];
    logic [31:0] got_a[$];
    logic [7:0]  frm[$];
    logic        exp_done;
    logic        exp_error;
    logic        exp_incomplete;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: captures every pulse and checks alignment and phase.
    always @(negedge clk) begin
        if (we) begin
            got_a.push_back(waddr);
            got_d.push_back(wdata);
            check("we_aligned", {30'd0, waddr[1:0]}, 32'd0);
            check("we_in_data", 32'(dbg_state), 32'(DATA));
        end
    end

    // ---------------- reference model ----------------
    // Derives expected writes and final status from the frame bytes alone.
    task automatic model_frame();
        logic [31:0] len;
        int          nfull;
        int          npay;
        logic [7:0]  sum;
        exp_q.delete();
        exp_a_q.delete();
        exp_done       = 1'b0;
        exp_error      = 1'b1;
        exp_incomplete = 1'b0;
        len = {frm[4], frm[3], frm[2], frm[1]};
        if (len > MAXW) return;
        nfull = (frm.size() - 5) / 4;
        if (nfull > int'(len)) nfull = int'(len);
        for (int i = 0; i < nfull; i++) begin
            exp_q.push_back({frm[5+4*i+3], frm[5+4*i+2], frm[5+4*i+1], frm[5+4*i]});
            exp_a_q.push_back(BASE + 32'(4 * i));
        end
        npay = 4 * int'(len);
        sum = 8'd0;
        for (int i = 0; i < npay && (5 + i) < frm.size(); i++) sum = sum + frm[5+i];
        if (frm.size() > 5 + npay) begin
            exp_done  = (frm[5+npay] == sum);
            exp_error = !exp_done;
        end else begin
            exp_incomplete = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build_frame(input int nwords, input bit bad_csum);
        logic [7:0] s;
        logic [7:0] b;
        frm.delete();
        frm.push_back(8'h55);
        frm.push_back(8'(nwords));
        frm.push_back(8'(nwords >> 8));
        frm.push_back(8'd0);
        frm.push_back(8'd0);
        s = 8'd0;
        for (int i = 0; i < 4 * nwords; i++) begin
            b = 8'($urandom);
            frm.push_back(b);
            s = s + b;
        end
        frm.push_back(bad_csum ? ~s : s);
    endtask

    task automatic run_frame(input int gmax);
        got_a.delete();
        got_d.delete();
        model_frame();
        foreach (frm[i]) begin
            send_byte(frm[i]);
            idle($urandom_range(0, gmax));
        end
        idle(exp_incomplete ? T + 4 : 3);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_nwr"}, 32'(got_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            check({tag, "_addr"}, got_a[i], exp_a_q[i]);
            check({tag, "_data"}, got_d[i], exp_q[i]);
        end
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_error));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(!exp_done));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        got_a.delete();
        got_d.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_waddr"}, waddr, BASE);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle(3);
        check_reset_values("rst_held");
        reset = 1'b0;
        idle(2);
        check_reset_values("rst_released");

        // Noise before any sync byte is ignored, and no timeout runs in IDLE.
        send_byte(8'h12);
        send_byte(8'h34);
        idle(2);
        send_byte(8'hAA);
        idle(T + 5);
        check_reset_values("noise");
        check("noise_nwr", 32'(got_d.size()), 32'd0);

        // Two-word program with a correct checksum.
        frm = {8'h55, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'hB0, 8'h00, 8'h37, 8'h11, 8'h00, 8'h10, 8'h9B};
        run_frame(2);
        check("f1_nwr_const", 32'(got_d.size()), 32'd2);
        if (got_d.size() == 2) begin
            check("f1_w0_addr", got_a[0], 32'h0000_0000);
            check("f1_w0_data", got_d[0], 32'h00B0_0093);
            check("f1_w1_addr", got_a[1], 32'h0000_0004);
            check("f1_w1_data", got_d[1], 32'h1000_1137);
        end
        check("f1_done_const", 32'(done), 32'd1);
        check_frame("f1");

        // Same program, wrong checksum: writes stay, frame reported bad.
        frm = {8'h55, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'hB0, 8'h00, 8'h37, 8'h11, 8'h00, 8'h10, 8'h00};
        run_frame(1);
        check("f2_error_const", 32'(error), 32'd1);
        check_frame("f2");

        // Empty image, then an oversize length.
        frm = {8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(1);
        check_frame("empty");
        frm = {8'h55, 8'h01, 8'h80, 8'h00, 8'h00};
        run_frame(1);
        check("oversize_error_const", 32'(error), 32'd1);
        check_frame("oversize");

        // Timeout after a partial word: error appears exactly at the limit.
        got_a.delete();
        got_d.delete();
        frm = {8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE};
        foreach (frm[i]) send_byte(frm[i]);
        idle(T - 1);
        check("to_before_error", 32'(error), 32'd0);
        check("to_before_busy", 32'(busy), 32'd1);
        idle(1);
        check("to_at_error", 32'(error), 32'd1);
        check("to_at_busy", 32'(busy), 32'd0);
        check("to_at_core_reset", 32'(core_reset), 32'd1);
        check("to_nwr", 32'(got_d.size()), 32'd0);

        // Reset in the middle of a frame, then a clean frame from BASE.
        build_frame(4, 1'b0);
        for (int i = 0; i < 15; i++) send_byte(frm[i]);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_a.delete();
        got_d.delete();
        build_frame(3, 1'b0);
        run_frame(2);
        check_frame("after_rst");

        // Eight words on back-to-back strobes.
        build_frame(8, 1'b0);
        run_frame(0);
        check_frame("b2b");

        // Randomized frames, some with corrupted checksums.
        for (int k = 0; k < 8; k++) begin
            build_frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
            run_frame(3);
            check_frame("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
